// File: rtl/i_decode.sv
`default_nettype none
// ============================================================================
// i_decode : MIPS ID stage - control decode, 32x32 register file, ID/EX latch
// Rev 1.0
// ============================================================================
module i_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_RD1,
  output logic [31:0] ID_EX_RD2,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_wr_en;
  logic [31:0] w_rf [32];

  assign w_opcode = IF_ID_IR[31:26];
  assign w_rs     = IF_ID_IR[25:21];
  assign w_rt     = IF_ID_IR[20:16];
  assign w_wr_en  = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

  // Register 0 has no storage, so it reads 0 and absorbs every write.
  assign w_rf[0] = 32'd0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_rf
      logic [31:0] reg_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= 32'd0;
        end else if (w_wr_en && (MEM_WB_WriteReg == 5'(gi))) begin
          reg_q <= MEM_WB_WriteData;
        end
      end
      assign w_rf[gi] = reg_q;
    end
  endgenerate

  // Write-through: a same-cycle write-back wins over the stale array value.
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  assign rd1_d = (w_wr_en && (MEM_WB_WriteReg == w_rs)) ? MEM_WB_WriteData : w_rf[w_rs];
  assign rd2_d = (w_wr_en && (MEM_WB_WriteReg == w_rt)) ? MEM_WB_WriteData : w_rf[w_rt];

  logic [1:0] wb_d;
  logic [2:0] m_d;
  logic [3:0] ex_d;

  always_comb begin
    wb_d = 2'b00;
    m_d  = 3'b000;
    ex_d = 4'b0000;
    case (w_opcode)
      c_OP_RTYPE: begin
        wb_d = 2'b10;
        ex_d = 4'b1100;
      end
      c_OP_LW: begin
        wb_d = 2'b11;
        m_d  = 3'b010;
        ex_d = 4'b0001;
      end
      c_OP_SW: begin
        m_d  = 3'b001;
        ex_d = 4'b0001;
      end
      c_OP_BEQ: begin
        m_d  = 3'b100;
        ex_d = 4'b0010;
      end
      default: ;
    endcase
  end

  logic [1:0]  wb_q;
  logic [2:0]  m_q;
  logic [3:0]  ex_q;
  logic [31:0] npc_q;
  logic [31:0] rd1_q;
  logic [31:0] rd2_q;
  logic [31:0] imm_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= 2'b00;
      m_q   <= 3'b000;
      ex_q  <= 4'b0000;
      npc_q <= 32'd0;
      rd1_q <= 32'd0;
      rd2_q <= 32'd0;
      imm_q <= 32'd0;
      rt_q  <= 5'd0;
      rd_q  <= 5'd0;
    end else begin
      wb_q  <= wb_d;
      m_q   <= m_d;
      ex_q  <= ex_d;
      npc_q <= IF_ID_NPC;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      imm_q <= {{16{IF_ID_IR[15]}}, IF_ID_IR[15:0]};
      rt_q  <= IF_ID_IR[20:16];
      rd_q  <= IF_ID_IR[15:11];
    end
  end

  assign ID_EX_WB  = wb_q;
  assign ID_EX_M   = m_q;
  assign ID_EX_EX  = ex_q;
  assign ID_EX_NPC = npc_q;
  assign ID_EX_RD1 = rd1_q;
  assign ID_EX_RD2 = rd2_q;
  assign ID_EX_IMM = imm_q;
  assign ID_EX_RT  = rt_q;
  assign ID_EX_RD  = rd_q;

endmodule
`default_nettype wire
